preg_free_arbiter: RTL and testbench
====================================

# preg_free_arbiter

Arbitrates physical-register release traffic from two requesters, retire and squash-reclaim, onto the freelist's two free ports (`free1`/`free2`, `free1_addr`/`free2_addr`). Up to two addresses per cycle are accepted from one granted requester, buffered in order in a small FIFO, and drained up to two per cycle. The block sits between the retire/recovery logic and the freelist that feeds `uop_decode`'s allocation.

## Interface
- `NUM_PREGS`, 64, physical register count; address width `PW = $clog2(NUM_PREGS)`.
- `FIFO_DEPTH`, 8, pending-address buffer entries; power of two, at least 4.
- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `ret_valid1`, `ret_valid2` in 1 each: retire lane valids. Lane 2 is meaningful only with lane 1; a lone `ret_valid2` is ignored.
- `ret_addr1`, `ret_addr2` in PW each: retire lane addresses.
- `ret_ready` out 1: retire request accepted this cycle.
- `sq_valid1`, `sq_valid2`, `sq_addr1`, `sq_addr2`: squash-reclaim lanes; same rules as the retire lanes.
- `sq_ready` out 1: squash request accepted this cycle.
- `drain_en` in 1: the freelist can take frees this cycle.
- `free1`, `free2` out 1 each: registered release strobes.
- `free1_addr`, `free2_addr` out PW each: registered release addresses.
- `pending` out `$clog2(FIFO_DEPTH)+1`: FIFO occupancy.
- `dup_err` out 1: sticky duplicate-release flag (see Configuration).

## Operation
- **Space check:** `space_ok = (FIFO_DEPTH - pending) >= 2`. It is evaluated on registered occupancy only, with no credit for the same cycle's drain.
- **Round-robin pointer:** `rr` is 0 when retire has priority, 1 when squash has priority. Reset value is 0.
- **Ready equations** (each depends only on the other requester's valid, so there is no combinational loop):
  - `ret_ready = space_ok && (!sq_valid1 || rr == 0)`.
  - `sq_ready = space_ok && (!ret_valid1 || rr == 1)`.
- **Transfer:** occurs when `X_valid1 && X_ready`. Lane 1 is pushed, then lane 2 if `X_valid2`. At most one requester is granted per cycle.
- **Pointer update:** after any transfer, `rr` points to the requester that was not granted. With no transfer, `rr` holds.
- **Drain:** when `drain_en`, pop `min(pending, 2)` entries in FIFO order. The older entry goes to `free1`/`free1_addr`, the newer to `free2`/`free2_addr`.
  - If only one entry is popped, `free2 = 0`.
  - When `!drain_en` or the FIFO is empty, `free1 = free2 = 0`. The address outputs then hold their last values.
- **Occupancy:** `pending_next = pending + pushed - popped`. A simultaneous push and pop in the same cycle is legal. Read/write pointers wrap modulo `FIFO_DEPTH`.
- **Full FIFO:** `pending > FIFO_DEPTH-2` deasserts both readies. Draining still proceeds.
- **Reset:** clears FIFO pointers, `pending = 0`, `free1 = free2 = 0`, `free1_addr = free2_addr = 0`, `rr = 0`, `dup_err = 0`. A reset asserted mid-operation discards every pending entry; no free strobes are emitted for them.

## Timing
- Ready is combinational in the request cycle. The push takes effect at that cycle's posedge (edge T).
- The earliest drain of a pushed entry is the cycle after T. The free strobe is registered at edge T+1 and is visible during cycle T+1..T+2, which is 2 edges after acceptance.
- `pending` updates at every edge and reflects both push and pop.
- `dup_err` sets at the edge of the offending push and stays set until reset.

## Configuration
- **Macro:** `PREG_FREE_DUP_CHECK_EN`.
- **Defined:** a `NUM_PREGS`-bit pending bitmap is kept. A bit sets on push and clears on pop.
  - A pushed lane whose address bit is already set, or that equals the other lane's address in the same transfer, is dropped (not written).
  - That drop sets `dup_err`.
  - The bitmap clears on reset.
- **Undefined:** no bitmap is built, all lanes are pushed unconditionally, and `dup_err` is tied to 0.

## Test plan
- **Basic ordering:** after reset, retire lanes `{5, 9}` valid for one cycle with `drain_en = 1` → `ret_ready = 1`. Two edges later `free1 = 1` / `free1_addr = 5` and `free2 = 1` / `free2_addr = 9`, then strobes return to 0 and `pending` returns to 0.
- **Contention:** both requesters valid every cycle with pairs and `drain_en = 1` → grants alternate retire, squash, retire, … starting with retire. `free` addresses appear in grant order. Neither requester is granted twice in a row.
- **Backpressure:** `drain_en = 0` with retire pushing pairs each cycle → `pending` goes 2, 4, 6, then `ret_ready = 0` at `pending = 8`. Setting `drain_en = 1` releases two entries per cycle in FIFO order, and ready reasserts once `pending <= 6`.
- **Odd count and wrap-around:** single-lane pushes 1, 2, 3 with `drain_en = 1` → pairs `{1, 2}` then `{3, –}` with `free2 = 0`. Sustained traffic past 8 entries preserves order across the pointer wrap.
- **Reset mid-operation:** `reset` asserted with `pending = 5` → on the next cycle `pending = 0`, `free1 = free2 = 0`, `rr = 0`, and no stale address is ever strobed.
- **Duplicate check (`PREG_FREE_DUP_CHECK_EN`):** push 7, then push `{7, 3}` while 7 is still pending → only 3 is enqueued and `dup_err = 1` stays sticky. Without the macro, both 7s are freed and `dup_err = 0`.

Source files
------------

// File: rtl/preg_free_arbiter.sv
// Round-robin merge of retire and squash-reclaim preg releases into an in-order FIFO drained
// up to two per cycle. Optional duplicate filter: define PREG_FREE_DUP_CHECK_EN.
module preg_free_arbiter #(
    parameter int unsigned NUM_PREGS  = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned PW = $clog2(NUM_PREGS),
    localparam int unsigned AW = $clog2(FIFO_DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ret_valid1,
    input  logic          ret_valid2,
    input  logic [PW-1:0] ret_addr1,
    input  logic [PW-1:0] ret_addr2,
    output logic          ret_ready,
    input  logic          sq_valid1,
    input  logic          sq_valid2,
    input  logic [PW-1:0] sq_addr1,
    input  logic [PW-1:0] sq_addr2,
    output logic          sq_ready,
    input  logic          drain_en,
    output logic          free1,
    output logic          free2,
    output logic [PW-1:0] free1_addr,
    output logic [PW-1:0] free2_addr,
    output logic [CW-1:0] pending,
    output logic          dup_err
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] pending_q, pending_d;
    logic [PW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] mem_d [FIFO_DEPTH];
    logic          rr_q, rr_d;
    logic          free1_q, free1_d, free2_q, free2_d;
    logic [PW-1:0] free1_addr_q, free1_addr_d, free2_addr_q, free2_addr_d;

    logic          space_ok, ret_xfer, sq_xfer;
    logic          sel_v1, sel_v2, push1, push2;
    logic [PW-1:0] sel_a1, sel_a2, head0, head1;
    logic [1:0]    n_push, n_pop;

    // Occupancy only; a same-cycle drain earns no credit.
    assign space_ok  = pending_q <= CW'(FIFO_DEPTH - 2);
    assign ret_ready = space_ok && (!sq_valid1 || !rr_q);
    assign sq_ready  = space_ok && (!ret_valid1 || rr_q);
    assign ret_xfer  = ret_valid1 && ret_ready;
    assign sq_xfer   = sq_valid1 && sq_ready;

    assign head0 = mem_q[rd_ptr_q];
    assign head1 = mem_q[rd_ptr_q + AW'(1)];

    always_comb begin
        sel_v1 = ret_xfer || sq_xfer;
        sel_v2 = ret_xfer ? ret_valid2 : (sq_xfer && sq_valid2);
        sel_a1 = sq_xfer ? sq_addr1 : ret_addr1;
        sel_a2 = sq_xfer ? sq_addr2 : ret_addr2;
    end

`ifdef PREG_FREE_DUP_CHECK_EN
    logic [NUM_PREGS-1:0] busy_q, busy_d;
    logic                 dup_err_q, dup_err_d;

    always_comb begin
        push1     = sel_v1 && !busy_q[sel_a1];
        // A pair naming the same preg twice keeps only the first.
        push2     = sel_v2 && !busy_q[sel_a2] && (sel_a2 != sel_a1);
        dup_err_d = dup_err_q || (sel_v1 && !push1) || (sel_v2 && !push2);
        busy_d    = busy_q;
        if (n_pop != 2'd0) busy_d[head0] = 1'b0;
        if (n_pop == 2'd2) busy_d[head1] = 1'b0;
        if (push1) busy_d[sel_a1] = 1'b1;
        if (push2) busy_d[sel_a2] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= '0;
            dup_err_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            dup_err_q <= dup_err_d;
        end
    end

    assign dup_err = dup_err_q;
`else
    assign push1   = sel_v1;
    assign push2   = sel_v2;
    assign dup_err = 1'b0;
`endif

    always_comb begin
        mem_d  = mem_q;
        n_push = {1'b0, push1} + {1'b0, push2};
        if (push1) mem_d[wr_ptr_q] = sel_a1;
        if (push2) mem_d[push1 ? wr_ptr_q + AW'(1) : wr_ptr_q] = sel_a2;
        wr_ptr_d = wr_ptr_q + AW'(n_push);

        n_pop = 2'd0;
        if (drain_en) n_pop = (pending_q >= CW'(2)) ? 2'd2 : pending_q[1:0];
        rd_ptr_d  = rd_ptr_q + AW'(n_pop);
        pending_d = pending_q + CW'(n_push) - CW'(n_pop);

        rr_d = rr_q;
        if (ret_xfer) begin
            rr_d = 1'b1;
        end else if (sq_xfer) begin
            rr_d = 1'b0;
        end

        free1_d      = n_pop != 2'd0;
        free2_d      = n_pop == 2'd2;
        free1_addr_d = free1_d ? head0 : free1_addr_q;
        free2_addr_d = free2_d ? head1 : free2_addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pending_q    <= '0;
            rr_q         <= 1'b0;
            free1_q      <= 1'b0;
            free2_q      <= 1'b0;
            free1_addr_q <= '0;
            free2_addr_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pending_q    <= pending_d;
            rr_q         <= rr_d;
            free1_q      <= free1_d;
            free2_q      <= free2_d;
            free1_addr_q <= free1_addr_d;
            free2_addr_q <= free2_addr_d;
        end
    end

    // Storage needs no reset: pointers and occupancy define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign free1      = free1_q;
    assign free2      = free2_q;
    assign free1_addr = free1_addr_q;
    assign free2_addr = free2_addr_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_preg_free_arbiter.sv
// Directed bench for preg_free_arbiter; honours PREG_FREE_DUP_CHECK_EN when defined.
module tb_preg_free_arbiter;

    localparam int unsigned PW = 6;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ret_valid1, ret_valid2, sq_valid1, sq_valid2, drain_en;
    logic [PW-1:0] ret_addr1, ret_addr2, sq_addr1, sq_addr2;
    logic          ret_ready, sq_ready, free1, free2, dup_err;
    logic [PW-1:0] free1_addr, free2_addr;
    logic [CW-1:0] pending;

    int total = 0;
    int bad   = 0;

    preg_free_arbiter #(
        .NUM_PREGS (64),
        .FIFO_DEPTH(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ret_valid1(ret_valid1),
        .ret_valid2(ret_valid2),
        .ret_addr1 (ret_addr1),
        .ret_addr2 (ret_addr2),
        .ret_ready (ret_ready),
        .sq_valid1 (sq_valid1),
        .sq_valid2 (sq_valid2),
        .sq_addr1  (sq_addr1),
        .sq_addr2  (sq_addr2),
        .sq_ready  (sq_ready),
        .drain_en  (drain_en),
        .free1     (free1),
        .free2     (free2),
        .free1_addr(free1_addr),
        .free2_addr(free2_addr),
        .pending   (pending),
        .dup_err   (dup_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_free(input string tag, input logic f1, input int a1,
                            input logic f2, input int a2);
        chk({tag, ".free1"}, 32'(free1), 32'(f1));
        chk({tag, ".free1_addr"}, 32'(free1_addr), 32'(a1));
        chk({tag, ".free2"}, 32'(free2), 32'(f2));
        chk({tag, ".free2_addr"}, 32'(free2_addr), 32'(a2));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ret(input logic v1, input logic v2, input int a1, input int a2);
        ret_valid1 = v1;
        ret_valid2 = v2;
        ret_addr1  = PW'(a1);
        ret_addr2  = PW'(a2);
    endtask

    task automatic set_sq(input logic v1, input logic v2, input int a1, input int a2);
        sq_valid1 = v1;
        sq_valid2 = v2;
        sq_addr1  = PW'(a1);
        sq_addr2  = PW'(a2);
    endtask

    task automatic idle();
        set_ret(1'b0, 1'b0, 0, 0);
        set_sq(1'b0, 1'b0, 0, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        drain_en = 1'b0;
        apply_reset();

        // Reset state
        chk("rst.pending", 32'(pending), 0);
        chk_free("rst", 1'b0, 0, 1'b0, 0);
        chk("rst.dup_err", 32'(dup_err), 0);
        chk("rst.ret_ready", 32'(ret_ready), 1);
        chk("rst.sq_ready", 32'(sq_ready), 1);

        // Basic ordering: {5,9} freed two edges after acceptance
        drain_en = 1'b1;
        set_ret(1'b1, 1'b1, 5, 9);
        #1;
        chk("basic.ret_ready", 32'(ret_ready), 1);
        chk("basic.sq_ready", 32'(sq_ready), 0);
        tick();
        idle();
        chk("basic.pending_t", 32'(pending), 2);
        chk("basic.free1_t", 32'(free1), 0);
        tick();
        chk_free("basic.t1", 1'b1, 5, 1'b1, 9);
        chk("basic.pending_t1", 32'(pending), 0);
        tick();
        chk_free("basic.t2", 1'b0, 5, 1'b0, 9);

        // Contention: retire first, then alternate
        apply_reset();
        drain_en = 1'b1;
        set_ret(1'b1, 1'b1, 10, 11);
        set_sq(1'b1, 1'b1, 20, 21);
        #1;
        chk("cont.c0.ret_ready", 32'(ret_ready), 1);
        chk("cont.c0.sq_ready", 32'(sq_ready), 0);
        tick();
        chk("cont.c0.pending", 32'(pending), 2);
        chk("cont.c0.free1", 32'(free1), 0);
        set_ret(1'b1, 1'b1, 12, 13);
        #1;
        chk("cont.c1.ret_ready", 32'(ret_ready), 0);
        chk("cont.c1.sq_ready", 32'(sq_ready), 1);
        tick();
        chk_free("cont.c1", 1'b1, 10, 1'b1, 11);
        set_sq(1'b1, 1'b1, 22, 23);
        #1;
        chk("cont.c2.ret_ready", 32'(ret_ready), 1);
        chk("cont.c2.sq_ready", 32'(sq_ready), 0);
        tick();
        chk_free("cont.c2", 1'b1, 20, 1'b1, 21);
        idle();
        tick();
        chk_free("cont.c3", 1'b1, 12, 1'b1, 13);
        chk("cont.c3.pending", 32'(pending), 0);

        // Backpressure: fill to 8 with drain off, then drain
        drain_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_ret(1'b1, 1'b1, 30 + 2 * k, 31 + 2 * k);
            #1;
            chk($sformatf("bp.fill%0d.ret_ready", k), 32'(ret_ready), 1);
            tick();
            chk($sformatf("bp.fill%0d.pending", k), 32'(pending), 32'(2 * k + 2));
        end
        set_ret(1'b1, 1'b1, 38, 39);
        #1;
        chk("bp.full.ret_ready", 32'(ret_ready), 0);
        tick();
        chk("bp.full.pending", 32'(pending), 8);
        chk("bp.full.free1", 32'(free1), 0);
        drain_en = 1'b1;
        #1;
        chk("bp.full_drain.ret_ready", 32'(ret_ready), 0);
        tick();
        chk_free("bp.d0", 1'b1, 30, 1'b1, 31);
        chk("bp.d0.pending", 32'(pending), 6);
        chk("bp.d0.ret_ready", 32'(ret_ready), 1);
        tick();
        idle();
        chk_free("bp.d1", 1'b1, 32, 1'b1, 33);
        chk("bp.d1.pending", 32'(pending), 6);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_free($sformatf("bp.d%0d", k + 2), 1'b1, 34 + 2 * k, 1'b1, 35 + 2 * k);
            chk($sformatf("bp.d%0d.pending", k + 2), 32'(pending), 32'(4 - 2 * k));
        end

        // Odd count plus an ignored lone lane 2
        drain_en = 1'b0;
        set_ret(1'b1, 1'b0, 1, 0);
        tick();
        set_ret(1'b1, 1'b0, 2, 0);
        tick();
        set_ret(1'b1, 1'b0, 3, 0);
        tick();
        set_ret(1'b0, 1'b1, 0, 50);
        tick();
        idle();
        chk("odd.pending", 32'(pending), 3);
        drain_en = 1'b1;
        tick();
        chk_free("odd.d0", 1'b1, 1, 1'b1, 2);
        chk("odd.d0.pending", 32'(pending), 1);
        tick();
        chk_free("odd.d1", 1'b1, 3, 1'b0, 2);
        chk("odd.d1.pending", 32'(pending), 0);
        tick();
        chk("odd.d2.free1", 32'(free1), 0);

        // Sustained pairs across the pointer wrap
        for (int k = 0; k < 6; k++) begin
            set_ret(1'b1, 1'b1, 40 + 2 * k, 41 + 2 * k);
            #1;
            chk($sformatf("wrap%0d.ret_ready", k), 32'(ret_ready), 1);
            tick();
            chk($sformatf("wrap%0d.pending", k), 32'(pending), 2);
            if (k > 0) begin
                chk_free($sformatf("wrap%0d", k), 1'b1, 38 + 2 * k, 1'b1, 39 + 2 * k);
            end
        end
        idle();
        tick();
        chk_free("wrap.last", 1'b1, 50, 1'b1, 51);
        chk("wrap.last.pending", 32'(pending), 0);

        // Reset with five entries pending; retire was granted last, so squash owns priority
        drain_en = 1'b0;
        set_ret(1'b1, 1'b1, 60, 61);
        tick();
        set_ret(1'b1, 1'b1, 62, 63);
        tick();
        set_ret(1'b1, 1'b0, 1, 0);
        tick();
        idle();
        chk("mid.pending", 32'(pending), 5);
        reset    = 1'b1;
        drain_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid.rst.pending", 32'(pending), 0);
        chk_free("mid.rst", 1'b0, 0, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid.stale%0d.free1", k), 32'(free1), 0);
            chk($sformatf("mid.stale%0d.free2", k), 32'(free2), 0);
        end
        set_ret(1'b1, 1'b1, 4, 5);
        set_sq(1'b1, 1'b1, 6, 7);
        #1;
        chk("mid.rr.ret_ready", 32'(ret_ready), 1);
        chk("mid.rr.sq_ready", 32'(sq_ready), 0);
        idle();
        tick();

        // Duplicate release of preg 7 while it is still pending
        drain_en = 1'b0;
        set_ret(1'b1, 1'b0, 7, 0);
        tick();
        set_ret(1'b1, 1'b1, 7, 3);
        tick();
        idle();
`ifdef PREG_FREE_DUP_CHECK_EN
        chk("dup.pending", 32'(pending), 2);
        chk("dup.dup_err", 32'(dup_err), 1);
        drain_en = 1'b1;
        tick();
        chk_free("dup.d0", 1'b1, 7, 1'b1, 3);
        chk("dup.d0.pending", 32'(pending), 0);
        tick();
        chk("dup.sticky", 32'(dup_err), 1);
        chk("dup.d1.free1", 32'(free1), 0);
`else
        chk("dup.pending", 32'(pending), 3);
        chk("dup.dup_err", 32'(dup_err), 0);
        drain_en = 1'b1;
        tick();
        chk_free("dup.d0", 1'b1, 7, 1'b1, 7);
        tick();
        chk_free("dup.d1", 1'b1, 3, 1'b0, 7);
        chk("dup.d1.dup_err", 32'(dup_err), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
